// File: rtl/forward_if.sv
// MEM-stage store-data forwarding bundle: MEM-stage controls/data in, forwarded store data out.
// Purely combinational signal group; there is no handshake, so there is no backpressure.
interface forward_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              mem_reg_write;
    logic              mem_mem_to_reg;
    logic              mem_mem_write;
    logic [REG_W-1:0]  mem_wr_reg;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              forward_f;
    logic [DATA_W-1:0] sel_data;

    modport master (
        output mem_reg_write, mem_mem_to_reg, mem_mem_write,
        output mem_wr_reg, mem_wr_data, mem_rd_data,
        input  forward_f, sel_data
    );

    modport slave (
        input  mem_reg_write, mem_mem_to_reg, mem_mem_write,
        input  mem_wr_reg, mem_wr_data, mem_rd_data,
        output forward_f, sel_data
    );
endinterface

// File: rtl/forward.sv
// Load-to-store data forwarding: replaces store data in MEM with the previous load's read data.
// Zero-cycle select from MEM inputs; tracked load applies one cycle later; no stall, no backpressure.
module forward #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    forward_if.slave bus
);

    typedef struct packed {
        logic              wb_reg_write;
        logic              wb_mem_to_reg;
        logic [REG_W-1:0]  wb_rd;
        logic [DATA_W-1:0] wb_data;
    } wbTrack_t;

    wbTrack_t wbTrack;
    logic     forwardF;

    // Only the instruction one stage ahead (now in WB) is tracked; anything older has already
    // written the register file and the store picked it up in ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbTrack <= '0;
        end else begin
            wbTrack.wb_reg_write  <= bus.mem_reg_write;
            wbTrack.wb_mem_to_reg <= bus.mem_mem_to_reg;
            wbTrack.wb_rd         <= bus.mem_wr_reg;
            wbTrack.wb_data       <= bus.mem_rd_data;
        end
    end

    // r0 is hard-wired zero, so a "load" into it must never be forwarded.
    always_comb begin
        forwardF = bus.mem_mem_write
                 & wbTrack.wb_reg_write
                 & wbTrack.wb_mem_to_reg
                 & (wbTrack.wb_rd == bus.mem_wr_reg)
                 & (wbTrack.wb_rd != '0);
    end

    assign bus.forward_f = forwardF;
    assign bus.sel_data  = forwardF ? wbTrack.wb_data : bus.mem_wr_data;

endmodule

// File: tb/tb_forward.sv
// Directed-vector bench for forward with a queue scoreboard and a decoupled negedge monitor.
module tb_forward;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct {
        string             name;
        logic              fwd;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic chkVld;
    int   checks;
    int   failures;
    bit   stimDone;
    exp_t expQ[$];

    forward_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    forward #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setInputs(input logic rw, input logic m2r, input logic mw,
                             input logic [REG_W-1:0] rg, input logic [DATA_W-1:0] wd,
                             input logic [DATA_W-1:0] rd);
        bus.mem_reg_write  = rw;
        bus.mem_mem_to_reg = m2r;
        bus.mem_mem_write  = mw;
        bus.mem_wr_reg     = rg;
        bus.mem_wr_data    = wd;
        bus.mem_rd_data    = rd;
    endtask

    task automatic expect_(input string nm, input logic f, input logic [DATA_W-1:0] d);
        exp_t e;
        e.name = nm;
        e.fwd  = f;
        e.data = d;
        expQ.push_back(e);
        chkVld = 1'b1;
    endtask

    // One MEM-stage cycle: inputs change just after the edge, monitor samples at the negedge.
    task automatic cycle(input logic rw, input logic m2r, input logic mw,
                         input logic [REG_W-1:0] rg, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] rd);
        @(posedge clk);
        #1;
        setInputs(rw, m2r, mw, rg, wd, rd);
        chkVld = 1'b0;
    endtask

    task automatic lw(input logic [REG_W-1:0] rg, input logic [DATA_W-1:0] rd);
        cycle(1'b1, 1'b1, 1'b0, rg, 32'h0, rd);
    endtask

    task automatic sw(input string nm, input logic [REG_W-1:0] rt, input logic [DATA_W-1:0] wd,
                      input logic f, input logic [DATA_W-1:0] d);
        cycle(1'b0, 1'b0, 1'b1, rt, wd, 32'h0);
        expect_(nm, f, d);
    endtask

    // Monitor: pops and compares whenever the stimulus side flags a checkable cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chkVld) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow got=empty required=entry");
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checks++;
                    if (bus.forward_f !== e.fwd) begin
                        failures++;
                        $display("FAIL %s.forward_f got=%0b required=%0b", e.name, bus.forward_f, e.fwd);
                    end
                    checks++;
                    if (bus.sel_data !== e.data) begin
                        failures++;
                        $display("FAIL %s.sel_data got=%08h required=%08h", e.name, bus.sel_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        stimDone = 1'b0;
        chkVld   = 1'b0;
        rst_n    = 1'b0;
        setInputs(1'b0, 1'b0, 1'b0, '0, '0, '0);

        // Reset state: a store that would match any tracked load still passes its own data.
        @(posedge clk);
        #1;
        setInputs(1'b1, 1'b1, 1'b1, 5'd24, 32'hCAFE0001, 32'h0BADF00D);
        expect_("reset_hold", 1'b0, 32'hCAFE0001);
        @(posedge clk);
        #1;
        setInputs(1'b0, 1'b0, 1'b1, 5'd24, 32'hCAFE0002, 32'h0);
        expect_("reset_hold2", 1'b0, 32'hCAFE0002);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chkVld = 1'b0;

        // lw r24 then sw r24: forwarded.
        lw(5'b11000, 32'hDEADBEEF);
        sw("lw_sw_match", 5'b11000, 32'h01010100, 1'b1, 32'hDEADBEEF);
        // lw r24 then sw r27: no match.
        lw(5'b11000, 32'hDEADBEEF);
        sw("lw_sw_mismatch", 5'b11011, 32'h01010101, 1'b0, 32'h01010101);
        // ALU write r24 then sw r24: not a load.
        cycle(1'b1, 1'b0, 1'b0, 5'b11000, 32'h0, 32'h55555555);
        sw("alu_sw", 5'b11000, 32'h11111111, 1'b0, 32'h11111111);
        // lw r0 then sw r0: zero register never forwards.
        lw(5'd0, 32'hFFFFFFFF);
        sw("lw_r0_sw", 5'd0, 32'h00000005, 1'b0, 32'h00000005);
        // lw r24, nop, sw r24: only the immediately preceding instruction counts.
        lw(5'b11000, 32'h99999999);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        sw("lw_nop_sw", 5'b11000, 32'h0000AAAA, 1'b0, 32'h0000AAAA);
        // lw r5, lw r6, sw r5 / sw after lw r6.
        lw(5'd5, 32'hA5A5A5A5);
        lw(5'd6, 32'h5A5A5A5A);
        sw("two_lw_old", 5'd5, 32'h00000077, 1'b0, 32'h00000077);
        lw(5'd5, 32'hA5A5A5A5);
        lw(5'd6, 32'h5A5A5A5A);
        sw("two_lw_new", 5'd6, 32'h00000078, 1'b1, 32'h5A5A5A5A);
        // Instruction with both MemWrite and MemToReg: forwards, then is itself tracked as a load.
        lw(5'd7, 32'h80000001);
        cycle(1'b1, 1'b1, 1'b1, 5'd7, 32'h00000011, 32'hFEDC0077);
        expect_("both_flags_fwd", 1'b1, 32'h80000001);
        sw("both_flags_tracked", 5'd7, 32'h00000022, 1'b1, 32'hFEDC0077);
        // sw with forwarding, same cycle a different data pattern (zero-cycle response).
        lw(5'd31, 32'h00000000);
        sw("lw_sw_zero_data", 5'd31, 32'hFFFFFFFF, 1'b1, 32'h00000000);

        // Reset asserted between edges after a load: tracking cleared asynchronously.
        lw(5'b11000, 32'h12345678);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        setInputs(1'b0, 1'b0, 1'b1, 5'b11000, 32'h01010100, 32'h0);
        expect_("async_reset_sw", 1'b0, 32'h01010100);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        expect_("first_sw_after_reset", 1'b0, 32'h01010100);
        // Capture resumes on the first edge after release.
        lw(5'b11000, 32'hABCD0001);
        sw("resume_capture", 5'b11000, 32'h01010100, 1'b1, 32'hABCD0001);

        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d required=0", expQ.size());
        end
        stimDone = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        if (!stimDone) begin
            $display("FAIL watchdog got=timeout required=finish");
            $fatal(1, "watchdog expired");
        end
    end

endmodule
